// File: rtl/mdr_mem_port_if.sv
// Bus between mdr_mem_port, the control unit and the memory subsystem.
// The slave modport is the data-path block; master is the control/memory side.
interface mdr_mem_port_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [DATA_W-1:0] busMuxOut;
   logic              mar_in;
   logic              mdr_in;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mdr_q;
   logic [ADDR_W-1:0] mar_q;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  busMuxOut, mar_in, mdr_in, mem_rd, mem_wr, mem_ack, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mdr_q, mar_q, busy, done, err
   );

   modport master (
      output busMuxOut, mar_in, mdr_in, mem_rd, mem_wr, mem_ack, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mdr_q, mar_q, busy, done, err
   );
endinterface

// File: rtl/mdr_mem_port.sv
// MAR/MDR data path with a memory request/acknowledge FSM.
// Optional ack timeout is enabled by defining MDR_MEM_TIMEOUT_EN.
module mdr_mem_port #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            clr,
   mdr_mem_port_if.slave   bus_io
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_WAIT = 3'd1;
   localparam logic [2:0] S_WR_WAIT = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_ERR     = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              req_q, we_q, busy_q, done_q;
   logic [ADDR_W-1:0] bus_addr;
   logic              start;
   logic              in_wait;

   // MAR takes the low bus bits, zero-filled when the address is wider than the bus.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_bit
         if (gi < DATA_W) begin : g_bus
            assign bus_addr[gi] = bus_io.busMuxOut[gi];
         end else begin : g_zero
            assign bus_addr[gi] = 1'b0;
         end
      end
   endgenerate

   assign start   = (state_q == S_IDLE) && (bus_io.mem_rd || bus_io.mem_wr);
   assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

`ifdef MDR_MEM_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       expired;

   // Expiry is only reached on an edge without ack, so a late ack still wins.
   assign expired = in_wait && !bus_io.mem_ack && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (start) begin
         cnt_d = 8'd0;
         err_d = 1'b0;
      end else if (expired) begin
         err_d = 1'b1;
      end else if (in_wait && !bus_io.mem_ack) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus_io.err = err_q;
`else
   logic expired;

   assign expired    = 1'b0;
   assign bus_io.err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      case (state_q)
         S_IDLE: begin
            // Loads land on the same edge as the request, so the transfer sees them.
            if (bus_io.mar_in) mar_d = bus_addr;
            if (bus_io.mdr_in) mdr_d = bus_io.busMuxOut;
            if (bus_io.mem_rd)      state_d = S_RD_WAIT;
            else if (bus_io.mem_wr) state_d = S_WR_WAIT;
         end
         S_RD_WAIT: begin
            if (bus_io.mem_ack) begin
               mdr_d   = bus_io.mem_rdata;
               state_d = S_DONE;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_WR_WAIT: begin
            if (bus_io.mem_ack)  state_d = S_DONE;
            else if (expired)    state_d = S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         req_q   <= (state_d == S_RD_WAIT) || (state_d == S_WR_WAIT);
         we_q    <= (state_d == S_WR_WAIT);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign bus_io.mem_req   = req_q;
   assign bus_io.mem_we    = we_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.mem_addr  = mar_q;
   assign bus_io.mem_wdata = mdr_q;
   assign bus_io.mdr_q     = mdr_q;
   assign bus_io.mar_q     = mar_q;
endmodule

// File: tb/tb_mdr_mem_port.sv
// Self-checking bench for mdr_mem_port: directed vector table, randomized
// transactions against a transaction-level model, and reset/ack/timeout sequences.
module tb_mdr_mem_port;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_txn = 0;

   logic [31:0] model_mar = '0;
   logic [31:0] model_mdr = '0;

   mdr_mem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

   mdr_mem_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .clr    (clr),
      .bus_io (bus_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pre_mar;
      logic        pre_mdr;
      logic [31:0] pre_bus;
      logic        rd;
      logic        wr;
      logic        ld_mar;
      logic        ld_mdr;
      logic [31:0] bus;
      int          waits;
      logic [31:0] rdata;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_mdr;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.busMuxOut = '0;
      bus_if.mar_in    = 1'b0;
      bus_if.mdr_in    = 1'b0;
      bus_if.mem_rd    = 1'b0;
      bus_if.mem_wr    = 1'b0;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = '0;
   endtask

   task automatic idle_load(input logic ld_mar, input logic ld_mdr, input logic [31:0] bus);
      bus_if.busMuxOut = bus;
      bus_if.mar_in    = ld_mar;
      bus_if.mdr_in    = ld_mdr;
      tick();
      idle_inputs();
      if (ld_mar) chk("idle_load_mar", bus_if.mar_q, bus);
      if (ld_mdr) chk("idle_load_mdr", bus_if.mdr_q, bus);
      chk("idle_load_busy", bus_if.busy, 1'b0);
   endtask

   // One complete transaction; junk requests/loads are driven while busy and must be ignored.
   task automatic run_txn(input logic rd, input logic wr, input logic ld_mar, input logic ld_mdr,
                          input logic [31:0] bus, input int waits, input logic [31:0] rdata,
                          input logic exp_we, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_mdr);
      bus_if.busMuxOut = bus;
      bus_if.mar_in    = ld_mar;
      bus_if.mdr_in    = ld_mdr;
      bus_if.mem_rd    = rd;
      bus_if.mem_wr    = wr;
      bus_if.mem_ack   = 1'b0;
      tick();
      for (int w = 0; w <= waits; w++) begin
         bus_if.busMuxOut = 32'hFFFF_FFFF ^ 32'($urandom_range(0, 255));
         bus_if.mar_in    = 1'b1;
         bus_if.mdr_in    = 1'b1;
         bus_if.mem_rd    = 1'($urandom_range(0, 1));
         bus_if.mem_wr    = 1'($urandom_range(0, 1));
         bus_if.mem_ack   = (w == waits);
         bus_if.mem_rdata = (w == waits) ? rdata : $urandom;
         chk("wait_req",   bus_if.mem_req, 1'b1);
         chk("wait_we",    bus_if.mem_we, exp_we);
         chk("wait_addr",  bus_if.mem_addr, exp_addr);
         chk("wait_wdata", bus_if.mem_wdata, exp_wdata);
         chk("wait_mdr",   bus_if.mdr_q, exp_wdata);
         chk("wait_busy",  bus_if.busy, 1'b1);
         chk("wait_done",  bus_if.done, 1'b0);
         chk("wait_err",   bus_if.err, 1'b0);
         tick();
      end
      bus_if.mem_ack   = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = $urandom;
      chk("done_pulse", bus_if.done, 1'b1);
      chk("done_req",   bus_if.mem_req, 1'b0);
      chk("done_busy",  bus_if.busy, 1'b1);
      chk("done_mdr",   bus_if.mdr_q, exp_mdr);
      chk("done_mar",   bus_if.mar_q, exp_addr);
      tick();
      idle_inputs();
      chk("after_done", bus_if.done, 1'b0);
      chk("after_busy", bus_if.busy, 1'b0);
      chk("after_req",  bus_if.mem_req, 1'b0);
      chk("after_mdr",  bus_if.mdr_q, exp_mdr);
      n_txn++;
      $display("txn %0d: %s addr=0x%08h waits=%0d mdr=0x%08h", n_txn, exp_we ? "WR" : "RD",
               exp_addr, waits, exp_mdr);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3, 32'hDEAD_BEEF,
                  1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 0, 32'h0,
                  1'b1, 32'h80, 32'h1234_5678, 32'h1234_5678};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1, 32'hA5A5_0001,
                  1'b0, 32'h80, 32'h1234_5678, 32'hA5A5_0001};
      vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 2, 32'h0BAD_F00D,
                  1'b0, 32'h100, 32'hA5A5_0001, 32'h0BAD_F00D};
      vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 4, 32'h0,
                  1'b1, 32'h100, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1, 32'h0,
                  1'b1, 32'h200, 32'h200, 32'h200};

      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",  bus_if.mem_req, 1'b0);
      chk("rst_we",   bus_if.mem_we, 1'b0);
      chk("rst_busy", bus_if.busy, 1'b0);
      chk("rst_done", bus_if.done, 1'b0);
      chk("rst_err",  bus_if.err, 1'b0);
      chk("rst_mdr",  bus_if.mdr_q, 32'h0);
      chk("rst_mar",  bus_if.mar_q, 32'h0);
      clr = 1'b0;
      tick();
      chk("post_rst_busy", bus_if.busy, 1'b0);

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].pre_mar || vecs[i].pre_mdr)
            idle_load(vecs[i].pre_mar, vecs[i].pre_mdr, vecs[i].pre_bus);
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].ld_mar, vecs[i].ld_mdr, vecs[i].bus,
                 vecs[i].waits, vecs[i].rdata, vecs[i].exp_we, vecs[i].exp_addr,
                 vecs[i].exp_wdata, vecs[i].exp_mdr);
      end
      model_mar = 32'h200;
      model_mdr = 32'h200;

      // Randomized transactions against the register-level model.
      for (int i = 0; i < 40; i++) begin
         logic        rd, wr, ld_mar, ld_mdr;
         logic [31:0] bus, rdata, wdata;
         int          waits;
         if ($urandom_range(0, 3) == 0) begin
            bus = $urandom;
            ld_mar = 1'($urandom_range(0, 1));
            ld_mdr = !ld_mar || 1'($urandom_range(0, 1));
            idle_load(ld_mar, ld_mdr, bus);
            if (ld_mar) model_mar = bus;
            if (ld_mdr) model_mdr = bus;
         end
         rd     = 1'($urandom_range(0, 1));
         wr     = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_mar = 1'($urandom_range(0, 1));
         ld_mdr = 1'($urandom_range(0, 1));
         bus    = $urandom;
         rdata  = $urandom;
         waits  = $urandom_range(0, 5);
         if (ld_mar) model_mar = bus;
         if (ld_mdr) model_mdr = bus;
         wdata = model_mdr;
         if (rd) model_mdr = rdata;
         run_txn(rd, wr, ld_mar, ld_mdr, bus, waits, rdata, !rd, model_mar, wdata, model_mdr);
      end

      // Ack while idle must not touch MDR or pulse done.
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = ~model_mdr;
      tick();
      tick();
      chk("idle_ack_mdr",  bus_if.mdr_q, model_mdr);
      chk("idle_ack_done", bus_if.done, 1'b0);
      chk("idle_ack_busy", bus_if.busy, 1'b0);
      idle_inputs();

`ifdef MDR_MEM_TIMEOUT_EN
      bus_if.mem_rd = 1'b1;
      tick();
      idle_inputs();
      for (int w = 1; w <= TIMEOUT; w++) begin
         chk("to_wait_req", bus_if.mem_req, 1'b1);
         chk("to_wait_err", bus_if.err, 1'b0);
         tick();
      end
      chk("to_err_req",  bus_if.mem_req, 1'b0);
      chk("to_err_flag", bus_if.err, 1'b1);
      chk("to_err_done", bus_if.done, 1'b0);
      chk("to_err_busy", bus_if.busy, 1'b1);
      tick();
      chk("to_idle_busy", bus_if.busy, 1'b0);
      chk("to_idle_err",  bus_if.err, 1'b1);
      chk("to_idle_done", bus_if.done, 1'b0);
      chk("to_idle_mdr",  bus_if.mdr_q, model_mdr);
      tick();
      chk("to_sticky_err", bus_if.err, 1'b1);
      begin
         logic [31:0] rdata;
         rdata = $urandom;
         run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, TIMEOUT - 1, rdata, 1'b0, model_mar,
                 model_mdr, rdata);
         model_mdr = rdata;
      end
`endif

      // Reset in the middle of a read abandons it immediately.
      bus_if.mem_rd = 1'b1;
      tick();
      idle_inputs();
      chk("mid_rst_pre_req", bus_if.mem_req, 1'b1);
      #2;
      clr = 1'b1;
      #1;
      chk("mid_rst_req",  bus_if.mem_req, 1'b0);
      chk("mid_rst_busy", bus_if.busy, 1'b0);
      chk("mid_rst_mdr",  bus_if.mdr_q, 32'h0);
      chk("mid_rst_mar",  bus_if.mar_q, 32'h0);
      chk("mid_rst_err",  bus_if.err, 1'b0);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h5555_AAAA;
      tick();
      clr = 1'b0;
      tick();
      idle_inputs();
      tick();
      chk("post_mid_rst_mdr",  bus_if.mdr_q, 32'h0);
      chk("post_mid_rst_done", bus_if.done, 1'b0);
      chk("post_mid_rst_busy", bus_if.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
- Parametrised next-generation memory data path: MAR and MDR plus a memory-handshake FSM.
- Replaces the static read-select MDR. The block now issues read/write transactions to external memory, waits for acknowledge, and captures or drives data by itself.
- Sits between the CPU internal bus (busMuxOut) and the memory subsystem. Controlled by the control unit via single-cycle mem_rd/mem_wr strobes.

Parameters:
- DATA_W, 32, width of MDR, busMuxOut, mem_rdata, mem_wdata.
- ADDR_W, 32, width of MAR and mem_addr.
- TIMEOUT, 15, maximum wait cycles for mem_ack before error (used only when the timeout feature is enabled); must be 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  asynchronous active-high reset.
- busMuxOut  in  DATA_W  internal bus value.
- mar_in  in  1  load MAR from busMuxOut[ADDR_W-1:0] (zero-extended if ADDR_W > DATA_W).
- mdr_in  in  1  load MDR from busMuxOut.
- mem_rd  in  1  start read transaction (strobe).
- mem_wr  in  1  start write transaction (strobe).
- mem_ack  in  1  memory acknowledge.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
- mem_req  out  1  transaction request to memory.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_W  always equals MAR.
- mem_wdata  out  DATA_W  always equals MDR.
- mdr_q  out  DATA_W  MDR contents (drives bus).
- mar_q  out  ADDR_W  MAR contents.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (clr=1, async): state=IDLE, MAR=0, MDR=0, mem_req=0, mem_we=0, busy=0, done=0, err=0, wait counter=0. Asserting clr mid-transaction drops mem_req immediately and abandons the transfer; MDR is not updated.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, ERR.
- IDLE:
  - mar_in and mdr_in load on the next edge; both may load in the same cycle.
  - mem_rd=1 -> RD_WAIT. mem_wr=1 -> WR_WAIT.
  - mem_rd and mem_wr together -> read wins; the write is dropped.
  - A load and a request in the same cycle: the load happens first, and the transaction uses the newly loaded MAR/MDR value.
  - Any new request clears err.
- RD_WAIT: mem_req=1, mem_we=0.
  - On an edge with mem_ack=1: MDR<=mem_rdata, -> DONE.
- WR_WAIT: mem_req=1, mem_we=1, mem_wdata=MDR.
  - On an edge with mem_ack=1: -> DONE. MDR is unchanged.
- DONE: done=1 for exactly one cycle, mem_req=0, -> IDLE. mdr_q shows the read data in this cycle.
- ERR (timeout only): err set, mem_req=0, -> IDLE next cycle. err stays 1 until the next mem_rd/mem_wr or clr.
- Outputs mem_req, mem_we, busy and done are registered and decoded from state only, with no combinational path from inputs.
- Latency: strobe sampled at edge N -> mem_req high in cycle N+1. Ack sampled at edge N+k -> done high in cycle N+k+1. Minimum request-to-done is 2 cycles.
- While busy: mar_in, mdr_in, mem_rd and mem_wr are ignored, so MAR/MDR are stable for the whole transaction.
- mem_ack in IDLE, DONE or ERR is ignored.

Optional Feature:
- Macro: MDR_MEM_TIMEOUT_EN.
- Defined:
  - The wait counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT with no ack -> ERR. No MDR update and no done pulse.
  - An ack on the same edge the counter hits TIMEOUT counts as success.
- Undefined: the FSM waits indefinitely, err is tied 0, and no counter logic is present.

Test Plan:
- Reset: drive clr=1 mid-RD_WAIT -> mem_req=0 the same cycle; mdr_q=0, mar_q=0, busy=0, err=0.
- Read: mar_in with bus=0x00000040, then mem_rd. Memory acks after 3 wait cycles with 0xDEADBEEF -> mem_addr=0x40, mem_we=0. mdr_q=0xDEADBEEF in the done cycle. done high exactly 1 cycle, 5 cycles after the strobe.
- Write: mdr_in with bus=0x12345678, mar_in with 0x80, then mem_wr. Ack on the first wait cycle -> mem_we=1 and mem_wdata=0x12345678 while mem_req=1. done pulses. mdr_q is unchanged.
- Priority/ignore: mem_rd and mem_wr in the same cycle -> read performed. Then mdr_in with 0xFFFFFFFF while busy -> mdr_q holds the read data.
- Same-cycle load and request: mar_in with 0x100 plus mem_rd in one cycle -> mem_addr=0x100 during RD_WAIT.
- Timeout (MDR_MEM_TIMEOUT_EN, TIMEOUT=15): no ack -> mem_req drops after 15 wait cycles, err=1, done never pulses, MDR unchanged. Next mem_rd clears err. An ack on wait cycle 15 completes normally.
